// File: rtl/nco_sweep_ctrl.sv
// nco_sweep_ctrl: frequency-sweep sequencer feeding the NCO phase increment and clock enable.
// Steps phi_inc from a latched start value to a latched stop value, holding each value for
// dwell+1 cycles, then completes (done pulse) or repeats.
// Build option: define NCO_SWEEP_TRIANGLE_EN to add a descending ramp (triangle sweep);
// without it the sweep is sawtooth only.
module nco_sweep_ctrl #(
  parameter int unsigned PHW     = 32,
  parameter int unsigned DWELL_W = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start_i,
  input  logic               abort_i,
  input  logic [PHW-1:0]     f_start_i,
  input  logic [PHW-1:0]     f_stop_i,
  input  logic [PHW-1:0]     f_step_i,
  input  logic [DWELL_W-1:0] dwell_i,
  input  logic               repeat_i,
  output logic [PHW-1:0]     phi_inc_o,
  output logic               clken_o,
  output logic               busy_o,
  output logic               done_o
);

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StRampUp = 2'd1
`ifdef NCO_SWEEP_TRIANGLE_EN
    ,
    StRampDn = 2'd2
`endif
  } state_e;

  state_e state_q, state_d;

  logic [PHW-1:0]     phi_q, phi_d;
  logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  // Sweep configuration, captured on start and held for the whole sweep.
  logic [PHW-1:0]     cfg_start_q, cfg_start_d;
  logic [PHW-1:0]     cfg_stop_q, cfg_stop_d;
  logic [PHW-1:0]     cfg_step_q, cfg_step_d;
  logic [DWELL_W-1:0] cfg_dwell_q, cfg_dwell_d;
  logic               cfg_repeat_q, cfg_repeat_d;

  logic               dwell_expired;
  logic               sweep_end;

  // Ascending step, evaluated one bit wider so a carry out clamps to stop instead of wrapping.
  logic [PHW:0]       sum_up;
  logic               up_clamp;
  logic [PHW-1:0]     phi_up;

  assign dwell_expired = (dwell_cnt_q == '0);

  // Next ascending value: phi + step, saturated at the stop register.
  always_comb begin
    sum_up   = {1'b0, phi_q} + {1'b0, cfg_step_q};
    up_clamp = (sum_up >= {1'b0, cfg_stop_q});
    phi_up   = up_clamp ? cfg_stop_q : sum_up[PHW-1:0];
  end

`ifdef NCO_SWEEP_TRIANGLE_EN
  // Descending step; the ramp only descends while phi >= start, so the span never underflows.
  logic [PHW:0]       dn_span;
  logic               dn_clamp;
  logic [PHW-1:0]     phi_dn;

  // Next descending value: phi - step, saturated at the start register.
  always_comb begin
    dn_span  = {1'b0, phi_q} - {1'b0, cfg_start_q};
    dn_clamp = (dn_span <= {1'b0, cfg_step_q});
    phi_dn   = dn_clamp ? cfg_start_q : (phi_q - cfg_step_q);
  end
`endif

  // Next-state logic: start/abort handling, dwell countdown and ramp stepping.
  always_comb begin
    state_d      = state_q;
    phi_d        = phi_q;
    dwell_cnt_d  = dwell_cnt_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    cfg_start_d  = cfg_start_q;
    cfg_stop_d   = cfg_stop_q;
    cfg_step_d   = cfg_step_q;
    cfg_dwell_d  = cfg_dwell_q;
    cfg_repeat_d = cfg_repeat_q;
    sweep_end    = 1'b0;

    if (abort_i && (state_q != StIdle)) begin
      // Abort beats dwell expiry and never produces a done pulse.
      state_d     = StIdle;
      phi_d       = '0;
      busy_d      = 1'b0;
      dwell_cnt_d = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_i && !abort_i) begin
            cfg_start_d  = f_start_i;
            // A stop below start collapses the sweep to a single dwell at start.
            cfg_stop_d   = (f_stop_i < f_start_i) ? f_start_i : f_stop_i;
            cfg_step_d   = f_step_i;
            cfg_dwell_d  = dwell_i;
            cfg_repeat_d = repeat_i;
            phi_d        = f_start_i;
            dwell_cnt_d  = dwell_i;
            busy_d       = 1'b1;
            state_d      = StRampUp;
          end
        end

        StRampUp: begin
          if (dwell_expired) begin
            dwell_cnt_d = cfg_dwell_q;
            if (phi_q != cfg_stop_q) begin
              // step == 0 leaves phi unchanged here: a fixed tone that only abort/reset ends.
              phi_d = phi_up;
`ifdef NCO_SWEEP_TRIANGLE_EN
            end else if (cfg_stop_q != cfg_start_q) begin
              state_d = StRampDn;
              phi_d   = phi_dn;
`endif
            end else begin
              sweep_end = 1'b1;
            end
          end else begin
            dwell_cnt_d = dwell_cnt_q - DWELL_W'(1);
          end
        end

`ifdef NCO_SWEEP_TRIANGLE_EN
        StRampDn: begin
          if (dwell_expired) begin
            dwell_cnt_d = cfg_dwell_q;
            if (phi_q != cfg_start_q) begin
              phi_d = phi_dn;
            end else begin
              sweep_end = 1'b1;
            end
          end else begin
            dwell_cnt_d = dwell_cnt_q - DWELL_W'(1);
          end
        end
`endif

        default: begin
          state_d     = StIdle;
          phi_d       = '0;
          busy_d      = 1'b0;
          dwell_cnt_d = '0;
        end
      endcase

      if (sweep_end) begin
        if (cfg_repeat_q) begin
          // Restart from start; in triangle mode start is therefore held for a further dwell.
          phi_d   = cfg_start_q;
          state_d = StRampUp;
        end else begin
          phi_d       = '0;
          busy_d      = 1'b0;
          done_d      = 1'b1;
          dwell_cnt_d = '0;
          state_d     = StIdle;
        end
      end
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      phi_q        <= '0;
      dwell_cnt_q  <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      cfg_start_q  <= '0;
      cfg_stop_q   <= '0;
      cfg_step_q   <= '0;
      cfg_dwell_q  <= '0;
      cfg_repeat_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      phi_q        <= phi_d;
      dwell_cnt_q  <= dwell_cnt_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      cfg_start_q  <= cfg_start_d;
      cfg_stop_q   <= cfg_stop_d;
      cfg_step_q   <= cfg_step_d;
      cfg_dwell_q  <= cfg_dwell_d;
      cfg_repeat_q <= cfg_repeat_d;
    end
  end

  assign phi_inc_o = phi_q;
  assign busy_o    = busy_q;
  assign clken_o   = busy_q;
  assign done_o    = done_q;

endmodule
